// File: rtl/bshifter_pkg.sv
// Shared types for the multi-cycle shifter: shift modes, FSM states and mode legality.
package bshifter_pkg;

    typedef enum logic [2:0] {
        LSL = 3'd0,
        LSR = 3'd1,
        ASR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encodings 5..7 are reserved and reported as errors.
    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= 3'd4);
    endfunction

endpackage

// File: rtl/bshifter_if.sv
// Request/response handshake bundle for bshifter_seq.
interface bshifter_if #(
    parameter int WIDTH = 16
);
    localparam int AMTW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_val;
    logic [AMTW-1:0]  in_amt;
    logic [2:0]       in_mode;
    logic             in_fill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_so;
    logic             out_err;

    modport master (
        output in_valid, in_val, in_amt, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_res, out_so, out_err
    );

    modport slave (
        input  in_valid, in_val, in_amt, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_res, out_so, out_err
    );

endinterface

// File: rtl/bshifter_step.sv
// Combinational single step: shifts/rotates a value by k (0..STEP) and reports the last bit out.
module bshifter_step
    import bshifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic [KW-1:0]    i_k,
    input  shift_mode_t      i_mode,
    input  logic             i_fill,
    input  logic             i_so,
    output logic [WIDTH-1:0] o_res,
    output logic             o_so
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [AW:0]      w_k;
    logic [AW:0]      w_back;
    logic [WIDTH-1:0] w_lo_mask;
    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_wrap_r;
    logic [WIDTH-1:0] w_wrap_l;
    logic [WIDTH-1:0] w_out_r;

    assign w_k       = (AW + 1)'(i_k);
    assign w_back    = (AW + 1)'(WIDTH) - w_k;
    assign w_lo_mask = ~(ONES << w_k);
    assign w_hi_mask = ~(ONES >> w_k);
    assign w_left    = i_val << w_k;
    assign w_right   = i_val >> w_k;
    // With k==0 the wrap terms shift by WIDTH and vanish, so no special case is needed.
    assign w_wrap_r  = i_val >> w_back;
    assign w_wrap_l  = i_val << w_back;
    assign w_out_r   = i_val >> (w_k - 1'b1);

    always_comb begin
        o_res = i_val;
        o_so  = i_so;
        case (i_mode)
            LSL:     o_res = w_left  | (i_fill ? w_lo_mask : '0);
            LSR:     o_res = w_right | (i_fill ? w_hi_mask : '0);
            ASR:     o_res = w_right | (i_val[WIDTH-1] ? w_hi_mask : '0);
            ROL:     o_res = w_left  | w_wrap_r;
            ROR:     o_res = w_right | w_wrap_l;
            default: o_res = i_val;
        endcase
        if (i_k != '0) begin
            case (i_mode)
                LSL, ROL:      o_so = w_wrap_r[0];
                LSR, ASR, ROR: o_so = w_out_r[0];
                default:       o_so = i_so;
            endcase
        end
    end

endmodule

// File: rtl/bshifter_seq.sv
// Multi-cycle shifter/rotator: accepts a request, shifts up to STEP bits per clock, holds the result until taken.
module bshifter_seq
    import bshifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic        clock,
    input  logic        reset,
    bshifter_if.slave   bus
);
    localparam int AMTW = $clog2(WIDTH);
    localparam int KW   = $clog2(STEP + 1);
    localparam logic [AMTW-1:0] STEP_A = AMTW'(STEP);
    localparam logic [KW-1:0]   STEP_K = KW'(STEP);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_res;
    logic             r_so;
    logic             r_err;
    logic [AMTW-1:0]  r_rem;
    shift_mode_t      r_mode;
    logic             r_fill;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_direct;
    logic [KW-1:0]    w_k;
    logic             w_last;
    logic [WIDTH-1:0] w_step_res;
    logic             w_step_so;

    assign w_accept = bus.in_valid && w_in_ready;
    // Illegal modes and zero amounts complete without entering SHIFT.
    assign w_direct = !mode_legal(bus.in_mode) || (bus.in_amt == '0);
    assign w_k      = (r_rem >= STEP_A) ? STEP_K : KW'(r_rem);
    assign w_last   = (r_rem == AMTW'(w_k));

    bshifter_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_val  (r_res),
        .i_k    (w_k),
        .i_mode (r_mode),
        .i_fill (r_fill),
        .i_so   (r_so),
        .o_res  (w_step_res),
        .o_so   (w_step_so)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_direct ? DONE : SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == IDLE) && !reset;
        w_out_valid = (r_state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_res  <= '0;
            r_so   <= 1'b0;
            r_err  <= 1'b0;
            r_rem  <= '0;
            r_mode <= LSL;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_res  <= bus.in_val;
            r_so   <= 1'b0;
            r_err  <= !mode_legal(bus.in_mode);
            r_rem  <= bus.in_amt;
            r_mode <= shift_mode_t'(bus.in_mode);
            r_fill <= bus.in_fill;
        end else if (r_state == SHIFT) begin
            r_res  <= w_step_res;
            r_so   <= w_step_so;
            r_rem  <= r_rem - AMTW'(w_k);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_res   = r_res;
    assign bus.out_so    = r_so;
    assign bus.out_err   = r_err;

endmodule

// File: doc/bshifter_seq.md
Name: bshifter_seq

Overview:
Parametrised multi-cycle shifter/rotator: accepts a WIDTH-bit operand, a shift amount and a mode over a valid/ready handshake, then shifts STEP bits per clock until done. It presents the result and the serial shift-out bit on a valid/ready output port. Generalises the fixed 16-bit one-bit-per-cycle shifter with width, step size, arithmetic/rotate modes, shift-out reporting and flow control. Used by datapath blocks needing variable shifts without a full-width barrel array.

Parameters:
WIDTH, 16, operand width; power of 2, >= 4.
STEP, 1, max bits shifted per cycle; power of 2, 1 <= STEP <= WIDTH/2.
AMTW, $clog2(WIDTH), derived localparam: shift amount width, range 0..WIDTH-1.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
in_val  in  WIDTH  operand.
in_amt  in  AMTW  shift amount.
in_mode  in  3  shift_mode_t: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR; 5-7 illegal.
in_fill  in  1  fill bit for LSL/LSR vacated positions.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_res  out  WIDTH  shifted result.
out_so  out  1  last bit shifted/rotated out.
out_err  out  1  illegal mode flag for this result.

Behaviour:
- Reset (async, active-high): state IDLE, out_res=0, out_so=0, out_err=0, out_valid=0; in_ready=0 while reset is high, 1 from the first cycle after deassertion.
- FSM states IDLE, SHIFT, DONE. in_ready = (state==IDLE) and not reset. No request overlap.
- IDLE: on in_valid&in_ready, capture val/amt/mode/fill into working regs and set so=0. Illegal mode: res=in_val, err=1, go to DONE. amt==0: res=in_val, so=0, go to DONE. Otherwise remaining=amt, go to SHIFT.
- SHIFT: each cycle shift by k=min(STEP, remaining), remaining-=k, update so. Go to DONE when remaining reaches 0 this cycle.
- Fill rules: LSL and LSR insert in_fill. ASR replicates the captured operand MSB. ROL/ROR wrap bits around.
- out_so equals the bit that one-bit-per-cycle shifting would emit last, independent of STEP. LSL/ROL: original bit[WIDTH-amt]. LSR/ASR/ROR: original bit[amt-1].
- DONE: out_valid=1. out_res/out_so/out_err stay stable until out_valid&out_ready. After the handshake the block returns to IDLE and out_valid drops next cycle. out_res holds its last value in IDLE.
- Latency: acceptance edge t gives out_valid at t+1+ceil(amt/STEP); amt 0 or illegal mode gives t+1.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset mid-SHIFT or mid-DONE aborts immediately to reset values. No partial result is emitted.

Decomposition:
- Package bshifter_pkg holds:
  - shift_mode_t enum (LSL, LSR, ASR, ROL, ROR) and mode legality function;
  - state_t enum (IDLE, SHIFT, DONE).
- One sub-module, bshifter_step. It is combinational: shifts a WIDTH-bit value by k in 0..STEP with mode and fill, and outputs the result and the last bit out. It is instantiated once; the FSM, counter and registers live in bshifter_seq.

Test Plan:
1. WIDTH=16, STEP=1: LSL, val 0x8001, amt 1, fill 0 -> out_res 0x0002, out_so 1, out_err 0, out_valid 2 cycles after accept.
2. STEP=1: ASR, val 0x8000, amt 4 -> out_res 0xF800, out_so 0, out_valid at accept+5.
3. STEP=4: ROR, val 0x0001, amt 15 -> steps 4,4,4,3, out_res 0x0002, out_so 0, out_valid at accept+5. Also LSR, val 0x00F0, amt 4, fill 1 -> out_res 0xF00F, out_so 0, accept+2.
4. LSR with amt 0, val 0x1234 -> out_res 0x1234, out_so 0, accept+1. Mode 5, val 0xABCD -> out_res 0xABCD, out_err 1, accept+1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 -> outputs stable, in_ready 0, no new capture. Raise out_ready -> handshake, IDLE next cycle, in_ready 1, out_valid 0.
6. Assert reset during SHIFT of a ROL with amt 7 -> all outputs 0 and in_ready 0 asynchronously. After deassertion in_ready=1, and a new LSL of 0x0001 by 3 returns 0x0008.
